// File: rtl/pc_ras.sv
// Program counter with relative branches, call/return and an internal return-address stack.
// Ports: clk, reset (sync, active-low); strobes inc/load/rel/call/ret; pc_in, offset;
//        outputs pc_out, ras_level, ras_full, ras_empty, ras_err (all registered or decoded from registers).
// Optional: define PC_RAS_WRAP_EN to make the RAS circular (call when full overwrites the oldest entry).
module pc_ras #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int               DEPTH     = 4,
    parameter int               OFF_W     = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         inc,
    input  logic                         load,
    input  logic                         rel,
    input  logic                         call,
    input  logic                         ret,
    input  logic [WIDTH-1:0]             pc_in,
    input  logic [OFF_W-1:0]             offset,
    output logic [WIDTH-1:0]             pc_out,
    output logic [$clog2(DEPTH+1)-1:0]   ras_level,
    output logic                         ras_full,
    output logic                         ras_empty,
    output logic                         ras_err
);

    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [LW-1:0]    level_q, level_d;
    logic             err_q, err_d;

    // Stack kept as a shift register: entry 0 is always the top. A push
    // shifts everything one slot deeper, so the oldest entry naturally falls
    // off the end when the stack is full (this is what gives circular mode).
    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [WIDTH-1:0] stk_d [DEPTH];

    logic [WIDTH-1:0] off_ext;
    logic [WIDTH-1:0] ret_addr;
    logic             full, empty;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    // Size cast of a signed operand sign-extends to WIDTH.
    assign off_ext  = WIDTH'($signed(offset));
    assign ret_addr = pc_q + WIDTH'(1);

    always_comb begin
        pc_d    = pc_q;
        level_d = level_q;
        err_d   = err_q;
        stk_d   = stk_q;

        if (call) begin
            pc_d = pc_in;
            if (!full) begin
                for (int i = DEPTH-1; i > 0; i--) stk_d[i] = stk_q[i-1];
                stk_d[0] = ret_addr;
                level_d  = level_q + LW'(1);
            end else begin
`ifdef PC_RAS_WRAP_EN
                // Oldest entry is shifted out; level saturates at DEPTH.
                for (int i = DEPTH-1; i > 0; i--) stk_d[i] = stk_q[i-1];
                stk_d[0] = ret_addr;
`else
                // Overflow: stack untouched, flag the error.
                err_d = 1'b1;
`endif
            end
        end else if (ret) begin
            if (!empty) begin
                pc_d = stk_q[0];
                for (int i = 0; i < DEPTH-1; i++) stk_d[i] = stk_q[i+1];
                level_d = level_q - LW'(1);
            end else begin
                err_d = 1'b1;
            end
        end else if (load) begin
            pc_d = pc_in;
        end else if (rel) begin
            pc_d = pc_q + off_ext;
        end else if (inc) begin
            pc_d = ret_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_VEC;
            level_q <= '0;
            err_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            level_q <= level_d;
            err_q   <= err_d;
        end
    end

    // Stack contents are don't-care after reset; only level_q says what is valid.
    always_ff @(posedge clk) begin
        stk_q <= stk_d;
    end

    assign pc_out    = pc_q;
    assign ras_level = level_q;
    assign ras_full  = full;
    assign ras_empty = empty;
    assign ras_err   = err_q;

endmodule

// File: tb/tb_pc_ras.sv
module tb_pc_ras;

    localparam int         DEPTH = 4;
    localparam logic [7:0] RV    = 8'h00;

    logic       clk = 1'b0;
    logic       reset, inc, load, rel, call, ret;
    logic [7:0] pc_in, offset;
    logic [7:0] pc_out;
    logic [2:0] ras_level;
    logic       ras_full, ras_empty, ras_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: PC value, LIFO as a queue (front = newest), sticky error.
    logic [7:0] m_pc;
    logic [7:0] m_stk[$];
    bit         m_err;

    always #5 clk = ~clk;

    pc_ras #(.WIDTH(8), .RESET_VEC(RV), .DEPTH(DEPTH), .OFF_W(8)) dut (
        .clk(clk), .reset(reset), .inc(inc), .load(load), .rel(rel),
        .call(call), .ret(ret), .pc_in(pc_in), .offset(offset),
        .pc_out(pc_out), .ras_level(ras_level), .ras_full(ras_full),
        .ras_empty(ras_empty), .ras_err(ras_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit rn, input bit c, input bit r, input bit l,
                              input bit rl, input bit i, input logic [7:0] pin,
                              input logic [7:0] off);
        int t;
        if (!rn) begin
            m_pc = RV;
            m_stk.delete();
            m_err = 1'b0;
        end else if (c) begin
            if (m_stk.size() < DEPTH) begin
                m_stk.push_front(m_pc + 8'd1);
            end else begin
`ifdef PC_RAS_WRAP_EN
                void'(m_stk.pop_back());
                m_stk.push_front(m_pc + 8'd1);
`else
                m_err = 1'b1;
`endif
            end
            m_pc = pin;
        end else if (r) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_front();
            else m_err = 1'b1;
        end else if (l) begin
            m_pc = pin;
        end else if (rl) begin
            t = int'(m_pc) + int'($signed(off));
            t = ((t % 256) + 256) % 256;
            m_pc = t[7:0];
        end else if (i) begin
            m_pc = m_pc + 8'd1;
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare 1ns later.
    task automatic cyc(input bit rn, input bit c, input bit r, input bit l,
                       input bit rl, input bit i, input logic [7:0] pin,
                       input logic [7:0] off);
        reset = rn; call = c; ret = r; load = l; rel = rl; inc = i;
        pc_in = pin; offset = off;
        @(posedge clk);
        model_step(rn, c, r, l, rl, i, pin, off);
        #1;
        chk("pc_out",    32'(pc_out),    32'(m_pc));
        chk("ras_level", 32'(ras_level), 32'(m_stk.size()));
        chk("ras_full",  32'(ras_full),  32'(m_stk.size() == DEPTH));
        chk("ras_empty", 32'(ras_empty), 32'(m_stk.size() == 0));
        chk("ras_err",   32'(ras_err),   32'(m_err));
    endtask

    logic [7:0] exp_rets [4];

    initial begin
        reset = 1'b0; inc = 0; load = 0; rel = 0; call = 0; ret = 0;
        pc_in = '0; offset = '0;
        m_pc = RV; m_err = 1'b0;

        // Reset and increment
        cyc(0,0,0,0,0,0,8'h00,8'h00);
        cyc(0,0,0,0,0,0,8'h00,8'h00);
        chk("reset_pc", 32'(pc_out), 32'h00);
        cyc(1,0,0,0,0,1,8'h00,8'h00);
        cyc(1,0,0,0,0,1,8'h00,8'h00);
        cyc(1,0,0,0,0,1,8'h00,8'h00);
        chk("inc3", 32'(pc_out), 32'h03);
        cyc(1,0,0,1,0,0,8'hFF,8'h00);
        cyc(1,0,0,0,0,1,8'h00,8'h00);
        chk("inc_wrap", 32'(pc_out), 32'h00);

        // Absolute and relative jumps
        cyc(1,0,0,1,0,0,8'h10,8'h00);
        cyc(1,0,0,0,1,0,8'h00,8'h05);
        chk("rel_pos", 32'(pc_out), 32'h15);
        cyc(1,0,0,0,1,0,8'h00,8'hFA);
        chk("rel_neg", 32'(pc_out), 32'h0F);
        cyc(1,0,0,1,0,0,8'h02,8'h00);
        cyc(1,0,0,0,1,0,8'h00,8'hFC);
        chk("rel_neg_wrap", 32'(pc_out), 32'hFE);

        // Call and return
        cyc(1,0,0,1,0,0,8'h20,8'h00);
        cyc(1,1,0,0,0,0,8'h80,8'h00);
        chk("call_pc", 32'(pc_out), 32'h80);
        cyc(1,0,0,0,0,1,8'h00,8'h00);
        cyc(1,0,0,0,0,1,8'h00,8'h00);
        cyc(1,0,1,0,0,0,8'h00,8'h00);
        chk("ret_pc", 32'(pc_out), 32'h21);

        // Nested calls up to full, then one more
        cyc(1,0,0,1,0,0,8'h00,8'h00);
        cyc(1,1,0,0,0,0,8'h10,8'h00);
        cyc(1,1,0,0,0,0,8'h20,8'h00);
        cyc(1,1,0,0,0,0,8'h30,8'h00);
        cyc(1,1,0,0,0,0,8'h40,8'h00);
        chk("full_after4", 32'(ras_full), 32'h1);
        cyc(1,1,0,0,0,0,8'h50,8'h00);
        chk("ovf_pc", 32'(pc_out), 32'h50);
`ifdef PC_RAS_WRAP_EN
        chk("ovf_err", 32'(ras_err), 32'h0);
        exp_rets = '{8'h41, 8'h31, 8'h21, 8'h11};
`else
        chk("ovf_err", 32'(ras_err), 32'h1);
        exp_rets = '{8'h31, 8'h21, 8'h11, 8'h01};
`endif
        for (int k = 0; k < 4; k++) begin
            cyc(1,0,1,0,0,0,8'h00,8'h00);
            chk("ovf_ret", 32'(pc_out), 32'(exp_rets[k]));
        end

        // Underflow and priority
        cyc(0,0,0,0,0,0,8'h00,8'h00);
        cyc(1,0,0,1,0,0,8'h33,8'h00);
        cyc(1,0,1,0,0,0,8'h00,8'h00);
        chk("udf_pc", 32'(pc_out), 32'h33);
        chk("udf_err", 32'(ras_err), 32'h1);
        cyc(1,0,0,1,0,1,8'h40,8'h00);
        chk("load_over_inc", 32'(pc_out), 32'h40);
        cyc(1,1,1,0,0,0,8'h60,8'h00);
        chk("call_over_ret", 32'(pc_out), 32'h60);
        chk("call_over_ret_lvl", 32'(ras_level), 32'h1);

        // Reset mid-operation
        cyc(1,1,0,0,0,0,8'h70,8'h00);
        cyc(1,1,0,0,0,0,8'h90,8'h00);
        cyc(0,0,1,0,0,0,8'h00,8'h00);
        chk("rst_ret_pc", 32'(pc_out), 32'(RV));
        chk("rst_ret_lvl", 32'(ras_level), 32'h0);
        chk("rst_ret_err", 32'(ras_err), 32'h0);
        cyc(1,0,1,0,0,0,8'h00,8'h00);
        chk("post_rst_udf", 32'(ras_err), 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 63) != 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 3) == 0),
                ($urandom_range(0, 1) == 0),
                8'($urandom), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_ras.md
Name: pc_ras

Overview:
- Parametrised program counter for the Ahmes-class CPU core.
- Extends the basic inc/load PC with PC-relative branches, a subroutine call/return mechanism and an internal return-address stack (RAS).
- Sits between the control unit, which drives command strobes, and the memory address path, which consumes pc_out.
- All updates are registered; a single clock and no combinational path from commands to pc_out.

Parameters:
- WIDTH, 8: PC and address width in bits.
- RESET_VEC, 0: value loaded into the PC on reset, WIDTH bits.
- DEPTH, 4: number of RAS entries, ≥1.
- OFF_W, 8: width of the signed relative-branch offset, ≤ WIDTH.

Ports:
- clk, input, 1: system clock, rising edge.
- reset, input, 1: synchronous, active-low reset; reset=0 at a rising edge resets the block.
- inc, input, 1: PC ← PC+1.
- load, input, 1: PC ← pc_in (absolute jump).
- rel, input, 1: PC ← PC + sign_extend(offset).
- call, input, 1: push PC+1 onto the RAS; PC ← pc_in.
- ret, input, 1: PC ← top of RAS; pop.
- pc_in, input, WIDTH: absolute target for load and call.
- offset, input, OFF_W: signed two's-complement branch offset.
- pc_out, output, WIDTH: current PC, registered.
- ras_level, output, $clog2(DEPTH+1): number of valid RAS entries.
- ras_full, output, 1: ras_level == DEPTH.
- ras_empty, output, 1: ras_level == 0.
- ras_err, output, 1: sticky overflow/underflow flag.

Behaviour:
- Interface: one clock (clk); synchronous active-low reset (reset). Reset is sampled only at the rising edge of clk.
- Reset (reset=0 at an edge):
  - pc_out ← RESET_VEC; ras_level ← 0; ras_err ← 0.
  - Stack contents are don't-care.
  - Reset overrides every command in the same cycle, including a call or ret in progress.
- Latency: commands are sampled at a rising edge; the new pc_out and flags are visible right after that edge. ras_full and ras_empty are decoded from the registered ras_level.
- Priority when several strobes are high in one cycle: call > ret > load > rel > inc > hold. Only the winning command takes effect; the others are ignored with no side effects.
- Hold: no strobe high → pc_out, RAS and flags unchanged.
- Arithmetic:
  - All PC arithmetic is modulo 2^WIDTH.
  - inc at all-ones wraps to 0.
  - rel sign-extends offset to WIDTH and wraps in both directions.
  - The return address pushed by call is (pc_out+1) mod 2^WIDTH.
- call when not full: push, ras_level+1, PC ← pc_in.
- call when full: see the Optional Feature section. The PC always takes pc_in.
- ret when not empty: PC ← top entry, ras_level−1.
- ret when empty (underflow): pc_out unchanged, ras_level stays 0, ras_err ← 1.
- ras_err:
  - Set by underflow, and by overflow in non-wrap mode.
  - Cleared only by reset.
  - Does not block further commands.
- RAS is LIFO: the most recently pushed valid entry is returned first.

Optional Feature:
- Macro: PC_RAS_WRAP_EN.
- Defined: the RAS is circular.
  - call when full overwrites the oldest entry; ras_level stays DEPTH; ras_err is not set.
  - Subsequent rets return the newest DEPTH addresses in LIFO order.
- Undefined:
  - call when full does not push; ras_level stays DEPTH; ras_err ← 1.
  - PC still ← pc_in.
  - Stored entries are unchanged.

Test Plan:
- Reset and increment: hold reset=0 for 2 edges → pc_out=RESET_VEC (0x00), ras_empty=1, ras_err=0. Release reset, inc=1 for 3 edges → pc_out 0x01, 0x02, 0x03. Then load pc_in=0xFF, then inc → 0x00 (wrap).
- Absolute and relative jumps: load pc_in=0x10 → 0x10. Then rel offset=0x05 → 0x15. Then rel offset=0xFA (−6) → 0x0F. From 0x02, rel offset=0xFC (−4) → 0xFE.
- Call and return: at pc_out=0x20, call pc_in=0x80 → pc_out=0x80, ras_level=1. inc twice → 0x82. ret → 0x21, ras_level=0, ras_empty=1.
- Nested overflow, DEPTH=4: 4 nested calls from 0x00, 0x10, 0x20, 0x30 → ras_full=1. A 5th call from 0x40 to 0x50:
  - Without the macro: pc_out=0x50, ras_err=1; 4 rets → 0x31, 0x21, 0x11, 0x01.
  - With the macro: ras_err=0; 4 rets → 0x41, 0x31, 0x21, 0x11.
- Underflow and priority:
  - ret with ras_empty=1 at pc_out=0x33 → pc_out stays 0x33, ras_err=1.
  - inc=1 and load=1 with pc_in=0x40 in the same cycle → 0x40.
  - call and ret in the same cycle → call wins.
- Reset mid-operation: after 2 calls, assert reset=0 together with ret=1 → pc_out=RESET_VEC, ras_level=0, ras_err=0. A following ret → ras_err=1.
